// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the scoreboarded register file
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 6;
  localparam int ZERO_ADDR  = 0;

  // LSB of port p's field in a packed multi-port vector of w-bit fields
  function automatic int slice_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read/write/reserve bus between issue, writeback and the register file
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;
  logic                     rsv_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_cnt, rsv_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_cnt, rsv_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit vector, busy counter and double-reserve detection
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rsv_en_i,
  input  logic [ADDR_W-1:0]      rsv_addr_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic                   flush_i,
  output logic [2**ADDR_W-1:0]   busy_nxt_o,
  output logic [ADDR_W:0]        busy_cnt_o,
  output logic                   rsv_err_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             rsv_ok, same_addr, inc, dec;

  assign rsv_ok    = rsv_en_i && !(ZERO_REG && rsv_addr_i == ADDR_W'(ZERO_ADDR));
  assign same_addr = (rsv_addr_i == wr_addr_i);

  // Release first, then reserve, so a same-cycle reserve of the released register wins
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
      if (rsv_ok)  busy_d[rsv_addr_i] = 1'b1;
    end
  end

  always_comb begin
    inc   = rsv_ok && !busy_q[rsv_addr_i];
    dec   = wr_en_i && busy_q[wr_addr_i] && !(rsv_ok && same_addr);
    cnt_d = flush_i ? '0 : cnt_q + CW'(inc) - CW'(dec);
    err_d = rsv_ok && !flush_i && busy_q[rsv_addr_i] && !(wr_en_i && same_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_nxt_o = busy_d;
  assign busy_cnt_o = cnt_q;
  assign rsv_err_o  = err_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with write-first bypass and busy scoreboard
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_sb_if.slave   bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_nxt;
  logic              wr_ok;

  assign wr_ok = bus.wr_en && !(ZERO_REG && bus.wr_addr == ADDR_W'(ZERO_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rsv_en_i   (bus.rsv_en),
    .rsv_addr_i (bus.rsv_addr),
    .wr_en_i    (bus.wr_en),
    .wr_addr_i  (bus.wr_addr),
    .flush_i    (bus.flush),
    .busy_nxt_o (busy_nxt),
    .busy_cnt_o (bus.busy_cnt),
    .rsv_err_o  (bus.rsv_err)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    localparam int AL = slice_lsb(p, ADDR_W);
    localparam int DL = slice_lsb(p, DATA_W);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_d, data_q;
    logic              busy_q;

    assign addr = bus.rd_addr[AL +: ADDR_W];

    always_comb begin
      if (ZERO_REG && addr == ADDR_W'(ZERO_ADDR)) data_d = '0;
      else if (bus.wr_en && bus.wr_addr == addr)  data_d = bus.wr_data;
      else                                        data_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_nxt[addr];
      end
    end

    assign bus.rd_data[DL +: DATA_W] = data_q;
    assign bus.rd_busy[p]            = busy_q;
  end

endmodule
